// File: rtl/cpu_ctrl_pkg.sv
// Shared control-step encodings for the bus transfer sequencer: states, op codes,
// ALU function selects and out_en bit positions for the non-GPR bus sources.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  typedef enum logic [2:0] {
    OP_MOVE  = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_MUL   = 3'd5,
    OP_DIV   = 3'd6,
    OP_FETCH = 3'd7
  } op_t;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_MUL = 4'd5,
    ALU_DIV = 4'd6,
    ALU_INC = 4'd7
  } alu_t;

  localparam int OE_HI  = 16;
  localparam int OE_LO  = 17;
  localparam int OE_ZHI = 18;
  localparam int OE_ZLO = 19;
  localparam int OE_PC  = 20;
  localparam int OE_MDR = 21;

  function automatic alu_t op_to_alu(op_t op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic logic is_muldiv(op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/gpr_select_decoder.sv
// Binary-to-one-hot register select with enable; all zeros when disabled.
module gpr_select_decoder #(
  parameter int N     = 16,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Control-step sequencer: fetch then register move / ALU op, driving one bus source
// per cycle and the matching register load enables, all decoded from registered state.
module bus_transfer_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_GPR = 16,
  parameter int OUT_W   = 24
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       start,
  input  logic [2:0]                 op,
  input  logic [$clog2(NUM_GPR)-1:0] ra,
  input  logic [$clog2(NUM_GPR)-1:0] rb,
  input  logic [$clog2(NUM_GPR)-1:0] rc,
  input  logic                       mem_ready,
  output logic [OUT_W-1:0]           out_en,
  output logic [NUM_GPR-1:0]         r_in,
  output logic                       pc_in,
  output logic                       mar_in,
  output logic                       mdr_in,
  output logic                       ir_in,
  output logic                       y_in,
  output logic                       z_in,
  output logic                       hi_in,
  output logic                       lo_in,
  output logic                       inc_pc,
  output logic                       mem_read,
  output logic [3:0]                 alu_op,
  output logic                       busy,
  output logic                       done
);

  localparam int RW = $clog2(NUM_GPR);

  state_t          state, state_nxt;
  op_t             op_q;
  logic [RW-1:0]   ra_q, rb_q, rc_q;
  logic            stalled;

  logic            src_en, dst_en;
  logic [RW-1:0]   src_sel;
  logic [NUM_GPR-1:0]       gpr_src;
  logic [OUT_W-1:NUM_GPR]   oe_sp;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      op_q    <= OP_MOVE;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      stalled <= 1'b0;
    end else begin
      state   <= state_nxt;
      // Marks T1 cycles after the first so pc_in is a single-cycle load.
      stalled <= (state == T1) && !mem_ready;
      if (state == IDLE && start) begin
        op_q <= op_t'(op);
        ra_q <= ra;
        rb_q <= rb;
        rc_q <= rc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = T0;
      T0:      state_nxt = T1;
      T1:      if (mem_ready) state_nxt = T2;
      T2:      state_nxt = (op_q == OP_FETCH) ? IDLE : T3;
      T3:      state_nxt = (op_q == OP_MOVE) ? IDLE : T4;
      T4:      state_nxt = T5;
      T5:      state_nxt = is_muldiv(op_q) ? T6 : IDLE;
      T6:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    oe_sp    = '0;
    src_en   = 1'b0;
    src_sel  = rb_q;
    dst_en   = 1'b0;
    pc_in    = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    hi_in    = 1'b0;
    lo_in    = 1'b0;
    inc_pc   = 1'b0;
    mem_read = 1'b0;
    alu_op   = ALU_NOP;
    done     = 1'b0;
    case (state)
      T0: begin
        oe_sp[OE_PC] = 1'b1;
        mar_in       = 1'b1;
        inc_pc       = 1'b1;
        z_in         = 1'b1;
        alu_op       = ALU_INC;
      end
      T1: begin
        oe_sp[OE_ZLO] = 1'b1;
        pc_in         = !stalled;
        mem_read      = 1'b1;
        mdr_in        = 1'b1;
      end
      T2: begin
        oe_sp[OE_MDR] = 1'b1;
        ir_in         = 1'b1;
        done          = (op_q == OP_FETCH);
      end
      T3: begin
        src_en = 1'b1;
        if (op_q == OP_MOVE) begin
          dst_en = 1'b1;
          done   = 1'b1;
        end else begin
          y_in = 1'b1;
        end
      end
      T4: begin
        src_en  = 1'b1;
        src_sel = rc_q;
        z_in    = 1'b1;
        alu_op  = op_to_alu(op_q);
      end
      T5: begin
        oe_sp[OE_ZLO] = 1'b1;
        if (is_muldiv(op_q)) begin
          lo_in = 1'b1;
        end else begin
          dst_en = 1'b1;
          done   = 1'b1;
        end
      end
      T6: begin
        oe_sp[OE_ZHI] = 1'b1;
        hi_in         = 1'b1;
        done          = 1'b1;
      end
      default: ;
    endcase
  end

  gpr_select_decoder #(.N(NUM_GPR)) u_src_dec (
    .en     (src_en),
    .sel    (src_sel),
    .onehot (gpr_src)
  );

  gpr_select_decoder #(.N(NUM_GPR)) u_dst_dec (
    .en     (dst_en),
    .sel    (ra_q),
    .onehot (r_in)
  );

  assign out_en = {oe_sp, gpr_src};
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench: vector table, hand-written corner sequences and random
// transactions compared cycle by cycle against a step-list reference model.
module tb_bus_transfer_sequencer;
  import cpu_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [3:0]  ra = '0, rb = '0, rc = '0;
  logic        mem_ready = 1'b0;
  logic [23:0] out_en;
  logic [15:0] r_in;
  logic        pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
  logic        inc_pc, mem_read, busy, done;
  logic [3:0]  alu_op;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bus_transfer_sequencer #(.NUM_GPR(16), .OUT_W(24)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .mem_ready(mem_ready), .out_en(out_en), .r_in(r_in), .pc_in(pc_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .inc_pc(inc_pc), .mem_read(mem_read), .alu_op(alu_op), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [23:0] oe;
    logic [15:0] rin;
    logic [9:0]  ctl;
    logic [3:0]  alu;
    logic        done;
    logic        busy;
  } obs_t;

  localparam int C_PC = 9, C_MAR = 8, C_MDR = 7, C_IR = 6, C_Y = 5, C_Z = 4;
  localparam int C_HI = 3, C_LO = 2, C_INC = 1, C_MRD = 0;

  obs_t act;
  assign act = {out_en, r_in, pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
                inc_pc, mem_read, alu_op, done, busy};

  obs_t exp_q[$];
  bit   mr_q[$];

  function automatic obs_t step(input logic [23:0] oe);
    obs_t s = '0;
    s.oe   = oe;
    s.busy = 1'b1;
    return s;
  endfunction

  // Expected per-cycle observation list for one instruction, from the step rules.
  task automatic build(input logic [2:0] o, input logic [3:0] a, b, c, input int stalls);
    obs_t s;
    logic [23:0] one = 24'h1;
    exp_q.delete();
    mr_q.delete();
    s = step(one << 20);
    s.ctl[C_MAR] = 1; s.ctl[C_INC] = 1; s.ctl[C_Z] = 1; s.alu = ALU_INC;
    exp_q.push_back(s); mr_q.push_back(1'($urandom));
    for (int j = 0; j <= stalls; j++) begin
      s = step(one << 19);
      s.ctl[C_PC] = (j == 0); s.ctl[C_MRD] = 1; s.ctl[C_MDR] = 1;
      exp_q.push_back(s); mr_q.push_back(j == stalls);
    end
    s = step(one << 21);
    s.ctl[C_IR] = 1; s.done = (o == 3'd7);
    exp_q.push_back(s); mr_q.push_back(1'($urandom));
    if (o == 3'd7) return;
    s = step(one << b);
    if (o == 3'd0) begin
      s.rin = 16'h1 << a; s.done = 1;
      exp_q.push_back(s); mr_q.push_back(1'($urandom));
      return;
    end
    s.ctl[C_Y] = 1;
    exp_q.push_back(s); mr_q.push_back(1'($urandom));
    s = step(one << c);
    s.ctl[C_Z] = 1;
    case (o)
      3'd1: s.alu = ALU_ADD;
      3'd2: s.alu = ALU_SUB;
      3'd3: s.alu = ALU_AND;
      3'd4: s.alu = ALU_OR;
      3'd5: s.alu = ALU_MUL;
      default: s.alu = ALU_DIV;
    endcase
    exp_q.push_back(s); mr_q.push_back(1'($urandom));
    s = step(one << 19);
    if (o < 3'd5) begin
      s.rin = 16'h1 << a; s.done = 1;
    end else begin
      s.ctl[C_LO] = 1;
    end
    exp_q.push_back(s); mr_q.push_back(1'($urandom));
    if (o >= 3'd5) begin
      s = step(one << 18);
      s.ctl[C_HI] = 1; s.done = 1;
      exp_q.push_back(s); mr_q.push_back(1'($urandom));
    end
  endtask

  task automatic run_txn(input logic [2:0] o, input logic [3:0] a, b, c, input int stalls,
                         output int lat, output logic [23:0] doe, output logic [15:0] drin);
    build(o, a, b, c, stalls);
    lat = 0; doe = '0; drin = '0;
    @(negedge clock);
    op = o; ra = a; rb = b; rc = c; start = 1'b1; mem_ready = 1'($urandom);
    @(posedge clock); #1;
    start = 1'b0;
    op = 3'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
    for (int k = 0; k < exp_q.size(); k++) begin
      mem_ready = mr_q[k];
      checks++;
      if (act !== exp_q[k]) begin
        errors++;
        $display("FAIL step op=%0d cyc=%0d got=%h want=%h", o, k + 1, act, exp_q[k]);
      end
      if (done && lat == 0) begin
        lat = k + 1; doe = out_en; drin = r_in;
      end
      @(posedge clock); #1;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after op=%0d got busy=%b done=%b want 0 0", o, busy, done);
    end
  endtask

  always @(negedge clock) begin
    checks++;
    if ($countones(out_en) > 1 || out_en[23:22] !== 2'b00) begin
      errors++;
      $display("FAIL onehot got out_en=%h want popcount<=1 and [23:22]=0", out_en);
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  ra, rb, rc;
    int          stalls;
    int          lat;
    logic [23:0] oe;
    logic [15:0] rin;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat;
    logic [23:0] doe;
    logic [15:0] drin;

    tbl[0] = '{3'd1, 4'd3,  4'd1,  4'd2,  0, 6, 24'h080000, 16'h0008};
    tbl[1] = '{3'd5, 4'd0,  4'd5,  4'd5,  0, 7, 24'h040000, 16'h0000};
    tbl[2] = '{3'd0, 4'd7,  4'd7,  4'd9,  3, 7, 24'h000080, 16'h0080};
    tbl[3] = '{3'd7, 4'd2,  4'd4,  4'd6,  0, 3, 24'h200000, 16'h0000};
    tbl[4] = '{3'd6, 4'd15, 4'd0,  4'd14, 1, 8, 24'h040000, 16'h0000};
    tbl[5] = '{3'd4, 4'd0,  4'd15, 4'd0,  0, 6, 24'h080000, 16'h0001};

    #2;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", act);
    end
    repeat (2) @(negedge clock);
    clear = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rc, tbl[i].stalls, lat, doe, drin);
      checks++;
      if (lat != tbl[i].lat || doe !== tbl[i].oe || drin !== tbl[i].rin) begin
        errors++;
        $display("FAIL vec%0d got lat=%0d oe=%h rin=%h want lat=%0d oe=%h rin=%h",
                 i, lat, doe, drin, tbl[i].lat, tbl[i].oe, tbl[i].rin);
      end
    end

    // Reset during T4 of an ADD.
    @(negedge clock);
    op = 3'd1; ra = 4'd3; rb = 4'd1; rc = 4'd2; mem_ready = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (out_en !== 24'h000004 || alu_op !== ALU_ADD) begin
      errors++;
      $display("FAIL pre_abort_t4 got oe=%h alu=%0d want oe=000004 alu=%0d", out_en, alu_op, ALU_ADD);
    end
    clear = 1'b0;
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL abort_outputs got=%h want=0", act);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_hold cyc=%0d got done=%b busy=%b want 0 0", k, done, busy);
      end
    end
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_release got busy=%b done=%b want 0 0", busy, done);
    end

    // start with SUB held high while a FETCH is running must be ignored.
    @(negedge clock);
    op = 3'd7; ra = 4'd1; rb = 4'd2; rc = 4'd3; mem_ready = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    op = 3'd2;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b1 || out_en !== 24'h200000) begin
      errors++;
      $display("FAIL busy_start got done=%b oe=%h want done=1 oe=200000", done, out_en);
    end
    start = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_idle got busy=%b want 0", busy);
    end

    for (int n = 0; n < 40; n++) begin
      run_txn(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)), lat, doe, drin);
      checks++;
      if (lat != exp_q.size()) begin
        errors++;
        $display("FAIL rand_lat n=%0d got=%0d want=%0d", n, lat, exp_q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
